// File: rtl/approx_mult_seq_engine.sv
// Sequential approximate multiplier engine: reads N_PAIRS operand pairs from a
// single-port memory, normalises each operand to its leading one, multiplies the
// top K bits, shifts the product back down and writes a 2W-bit result per pair.
module approx_mult_seq_engine #(
  parameter int W        = 16,
  parameter int K        = 8,
  parameter int N_PAIRS  = 4,
  parameter int AW       = 8,
  parameter int IN_BASE  = 0,
  parameter int OUT_BASE = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic [AW-1:0]   mem_addr,
  output logic            mem_rd,
  input  logic [W-1:0]    mem_rdata,
  output logic            mem_wr,
  output logic [2*W-1:0]  mem_wdata,
  output logic            busy,
  output logic            done
);

  localparam int SH_W  = (W > 1) ? $clog2(W) : 1;
  localparam int S_W   = (W > 1) ? $clog2(2*W-1) : 1;
  localparam int IDX_W = (N_PAIRS > 1) ? $clog2(N_PAIRS) : 1;

  typedef enum logic [3:0] {
    ST_IDLE, ST_WAIT, ST_RD_A, ST_LD_A, ST_RD_B, ST_LD_B,
    ST_NORM_A, ST_NORM_B, ST_MUL, ST_DENORM, ST_WRITE, ST_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [SH_W-1:0]  sha_q, sha_d;
  logic [SH_W-1:0]  shb_q, shb_d;
  logic [S_W-1:0]   s_q, s_d;
  logic [2*W-1:0]   r_q, r_d;

  // Truncated product of the normalised operands, aligned to the top of 2W bits.
  logic [K-1:0]     top_a, top_b;
  logic [2*W-1:0]   prod_w;
  always_comb begin
    top_a  = a_q[W-1 -: K];
    top_b  = b_q[W-1 -: K];
    prod_w = ((2*W)'(top_a) * (2*W)'(top_b)) << (2*W - 2*K);
  end

  // Next-state and datapath update; zero operands skip straight to WRITE so the
  // normalise loop never spins on an operand without a leading one.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    sha_d   = sha_q;
    shb_d   = shb_q;
    s_d     = s_q;
    r_d     = r_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_WAIT;
      ST_WAIT: begin
        if (!start) begin
          idx_d   = '0;
          state_d = ST_RD_A;
        end
      end
      ST_RD_A: state_d = ST_LD_A;
      ST_LD_A: begin
        a_d     = mem_rdata;
        sha_d   = '0;
        state_d = ST_RD_B;
      end
      ST_RD_B: state_d = ST_LD_B;
      ST_LD_B: begin
        b_d   = mem_rdata;
        shb_d = '0;
        r_d   = '0;
        if (a_q == '0 || mem_rdata == '0) state_d = ST_WRITE;
        else                              state_d = ST_NORM_A;
      end
      ST_NORM_A: begin
        if (!a_q[W-1]) begin
          a_d   = a_q << 1;
          sha_d = sha_q + 1'b1;
        end else begin
          state_d = ST_NORM_B;
        end
      end
      ST_NORM_B: begin
        if (!b_q[W-1]) begin
          b_d   = b_q << 1;
          shb_d = shb_q + 1'b1;
        end else begin
          state_d = ST_MUL;
        end
      end
      ST_MUL: begin
        r_d     = prod_w;
        s_d     = S_W'(sha_q) + S_W'(shb_q);
        state_d = ST_DENORM;
      end
      ST_DENORM: begin
        if (s_q != '0) begin
          r_d = r_q >> 1;
          s_d = s_q - 1'b1;
        end else begin
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (idx_q == IDX_W'(N_PAIRS - 1)) begin
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = ST_RD_A;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Moore outputs decoded from the current state; addresses wrap modulo 2^AW.
  always_comb begin
    mem_addr  = '0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    done      = 1'b0;
    busy      = !(state_q == ST_IDLE || state_q == ST_WAIT);
    mem_wdata = r_q;
    case (state_q)
      ST_RD_A: begin
        mem_rd   = 1'b1;
        mem_addr = AW'(IN_BASE + 2 * int'(idx_q));
      end
      ST_RD_B: begin
        mem_rd   = 1'b1;
        mem_addr = AW'(IN_BASE + 2 * int'(idx_q) + 1);
      end
      ST_WRITE: begin
        mem_wr   = 1'b1;
        mem_addr = AW'(OUT_BASE + int'(idx_q));
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  // State and datapath registers; reset clears everything so outputs read zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sha_q   <= '0;
      shb_q   <= '0;
      s_q     <= '0;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sha_q   <= sha_d;
      shb_q   <= shb_d;
      s_q     <= s_d;
      r_q     <= r_d;
    end
  end

endmodule

// File: tb/tb_approx_mult_seq_engine.sv
// Directed testbench for approx_mult_seq_engine with default parameters.
module tb_approx_mult_seq_engine;

  localparam int W  = 16;
  localparam int AW = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [AW-1:0]   mem_addr;
  logic            mem_rd;
  logic [W-1:0]    mem_rdata = '0;
  logic            mem_wr;
  logic [2*W-1:0]  mem_wdata;
  logic            busy;
  logic            done;

  approx_mult_seq_engine dut (
    .clk(clk), .rst(rst), .start(start),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
    .mem_wr(mem_wr), .mem_wdata(mem_wdata), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Synchronous read memory: data appears the cycle after the read strobe.
  logic [W-1:0] mem [0:255];
  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= mem[mem_addr];
  end

  // Bus monitor, sampled on the falling edge.
  int          cyc = 0;
  int          rda_cyc [0:3];
  logic [7:0]  wr_addr [0:15];
  logic [31:0] wr_data [0:15];
  int          wr_cyc  [0:15];
  int          nwr = 0;
  int          done_cnt = 0;
  int          done_cyc = -1;
  int          busy_fall_cyc = -1;
  logic        busy_prev = 1'b0;
  logic        busy_at_done = 1'b0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (mem_rd && !mem_addr[0] && mem_addr < 8) rda_cyc[int'(mem_addr >> 1)] = cyc;
    if (mem_wr && nwr < 16) begin
      wr_addr[nwr] = mem_addr;
      wr_data[nwr] = mem_wdata;
      wr_cyc[nwr]  = cyc;
      nwr = nwr + 1;
    end
    if (done) begin
      done_cnt     = done_cnt + 1;
      done_cyc     = cyc;
      busy_at_done = busy;
    end
    if (busy_prev && !busy) busy_fall_cyc = cyc;
    busy_prev = busy;
  end

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs [0:7];
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_log();
    nwr = 0; done_cnt = 0; done_cyc = -1; busy_fall_cyc = -1;
    for (int i = 0; i < 4; i++) rda_cyc[i] = -1;
  endtask

  task automatic run_start(input int hold);
    @(posedge clk); #1 start = 1'b1;
    repeat (hold) @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (done_cnt == 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", (done_cnt > 0) ? 64'd1 : 64'd0, 64'd1);
  endtask

  initial begin
    vecs[0] = '{16'h0003, 16'h0005, 32'h0000000F, 63};
    vecs[1] = '{16'h8000, 16'h8000, 32'h40000000, 9};
    vecs[2] = '{16'hFFFF, 16'hFFFF, 32'hFE010000, 9};
    vecs[3] = '{16'h0000, 16'h1234, 32'h00000000, 5};
    vecs[4] = '{16'h1234, 16'h0000, 32'h00000000, 5};
    vecs[5] = '{16'h0001, 16'h0001, 32'h00000001, 69};
    vecs[6] = '{16'h00FF, 16'h0100, 32'h0000FF00, 39};
    vecs[7] = '{16'h1234, 16'h5678, 32'h0616C000, 17};
    for (int i = 0; i < 256; i++) mem[i] = '0;

    rst = 1'b1; start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_addr",  64'(mem_addr),  64'd0);
    check("rst_rd_wr", {62'd0, mem_rd, mem_wr}, 64'd0);
    check("rst_wdata", 64'(mem_wdata), 64'd0);
    check("rst_busy_done", {62'd0, busy, done}, 64'd0);
    rst = 1'b0;

    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++) begin
        mem[2*i]   = vecs[r*4+i].a;
        mem[2*i+1] = vecs[r*4+i].b;
      end
      clear_log();
      run_start((r == 0) ? 3 : 1);
      if (r == 0) begin
        repeat (10) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
      end
      wait_done();
      repeat (3) @(negedge clk);
      check($sformatf("r%0d_nwr", r), 64'(nwr), 64'd4);
      for (int i = 0; i < 4; i++) begin
        check($sformatf("r%0d_p%0d_addr", r, i), 64'(wr_addr[i]), 64'(8 + i));
        check($sformatf("r%0d_p%0d_data", r, i), 64'(wr_data[i]), 64'(vecs[r*4+i].exp));
        check($sformatf("r%0d_p%0d_lat", r, i), 64'(wr_cyc[i] - rda_cyc[i] + 1), 64'(vecs[r*4+i].lat));
      end
      check($sformatf("r%0d_done_gap", r), 64'(done_cyc - wr_cyc[3]), 64'd1);
      check($sformatf("r%0d_done_cnt", r), 64'(done_cnt), 64'd1);
      check($sformatf("r%0d_busy_at_done", r), 64'(busy_at_done), 64'd1);
      check($sformatf("r%0d_busy_fall", r), 64'(busy_fall_cyc - done_cyc), 64'd1);
      repeat (20) @(negedge clk);
      check($sformatf("r%0d_idle_nwr", r), 64'(nwr), 64'd4);
      check($sformatf("r%0d_idle_busy", r), 64'(busy), 64'd0);
    end

    // Reset in the middle of pair 1's A normalisation.
    mem[0] = 16'h8000; mem[1] = 16'h8000;
    mem[2] = 16'h0001; mem[3] = 16'h0001;
    clear_log();
    run_start(1);
    begin
      int n = 0;
      while (!(mem_rd && mem_addr == 8'd3) && n < 500) begin
        @(negedge clk);
        n++;
      end
      check("rst_seen_rdb1", (n < 500) ? 64'd1 : 64'd0, 64'd1);
    end
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_addr", 64'(mem_addr), 64'd0);
    check("mid_rst_ctrl", {60'd0, mem_rd, mem_wr, busy, done}, 64'd0);
    check("mid_rst_wdata", 64'(mem_wdata), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    check("mid_rst_pre_writes", 64'(nwr), 64'd1);
    repeat (40) @(posedge clk);
    #1;
    check("mid_rst_no_write", 64'(nwr), 64'd1);
    check("mid_rst_idle", {62'd0, busy, mem_rd}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
